mem_ctrl: RTL and testbench

- Byte-serial memory controller sitting directly upstream of the instruction fetch stage.
- Converts word fetch requests from fetch and 1/2/4-byte load/store requests from the memory-access stage into sequences on the 8-bit single-port RAM bus.
- Assembles fetched bytes little-endian and returns each result with a one-cycle ok pulse; fetch consumes if_ok/if_data as its ok/dt inputs.
- Arbitrates between the two requesters, with load/store taking priority.

---
 rtl/mem_ctrl_if.sv | 31 +++
 rtl/mem_ctrl.sv | 165 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// Signal bundle between the fetch / load-store requesters, mem_ctrl and the byte-wide RAM.
// The slave modport is the controller's view; master is the environment (requesters + RAM).
interface mem_ctrl_if #(
    parameter int ADDR_W = 17
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_ok;
    logic [31:0]       if_data;
    logic              ls_req;
    logic              ls_we;
    logic [1:0]        ls_len;
    logic [31:0]       ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_ok;
    logic [31:0]       ls_rdata;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic [7:0]        mem_dout;
    logic [7:0]        mem_din;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
        output if_ok, if_data, ls_ok, ls_rdata, mem_a, mem_wr, mem_dout
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_len, ls_addr, ls_wdata, mem_din,
        input  if_ok, if_data, ls_ok, ls_rdata, mem_a, mem_wr, mem_dout
    );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial controller turning fetch words and 1/2/4-byte load/stores into 8-bit RAM cycles.
// Load/store wins arbitration; results are assembled little-endian and flagged by a one-cycle ok.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input logic       clk,
    input logic       rst,
    mem_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state, state_nxt;
    logic [2:0]        cnt, cnt_nxt;
    logic [2:0]        len_n, len_nxt;
    logic              owner_ls, owner_nxt;
    logic [31:0]       base, base_nxt;
    logic [31:0]       wdata, wdata_nxt;
    logic [31:0]       asm_buf, asm_nxt;
    logic              if_ok_nxt, ls_ok_nxt, mem_wr_nxt;
    logic [31:0]       if_data_nxt, ls_rdata_nxt;
    logic [ADDR_W-1:0] mem_a_nxt;
    logic [7:0]        mem_dout_nxt;
    logic [1:0]        rd_idx;
    logic [31:0]       merged;

    function automatic logic [ADDR_W-1:0] addr_at(input logic [31:0] b, input logic [2:0] k);
        return ADDR_W'(b + {29'd0, k});
    endfunction

    function automatic logic [2:0] len_decode(input logic [1:0] code);
        case (code)
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    function automatic logic [7:0] get_byte(input logic [31:0] w, input logic [1:0] idx);
        return w[{idx, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                             input logic [7:0] b);
        logic [31:0] r;
        r = w;
        r[{idx, 3'b000} +: 8] = b;
        return r;
    endfunction

    // In READ, cnt counts cycles from 1; the byte on mem_din at cycle cnt belongs to index cnt-2.
    assign rd_idx = cnt[1:0] - 2'd2;
    assign merged = put_byte(asm_buf, rd_idx, bus.mem_din);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        len_nxt      = len_n;
        owner_nxt    = owner_ls;
        base_nxt     = base;
        wdata_nxt    = wdata;
        asm_nxt      = asm_buf;
        if_ok_nxt    = 1'b0;
        ls_ok_nxt    = 1'b0;
        if_data_nxt  = bus.if_data;
        ls_rdata_nxt = bus.ls_rdata;
        mem_a_nxt    = bus.mem_a;
        mem_wr_nxt   = 1'b0;
        mem_dout_nxt = bus.mem_dout;
        case (state)
            IDLE: begin
                mem_a_nxt = '0;
                cnt_nxt   = 3'd0;
                if (bus.ls_req) begin
                    base_nxt  = bus.ls_addr;
                    len_nxt   = len_decode(bus.ls_len);
                    owner_nxt = 1'b1;
                    wdata_nxt = bus.ls_wdata;
                    asm_nxt   = 32'd0;
                    cnt_nxt   = 3'd1;
                    mem_a_nxt = addr_at(bus.ls_addr, 3'd0);
                    if (bus.ls_we) begin
                        state_nxt    = WRITE;
                        mem_wr_nxt   = 1'b1;
                        mem_dout_nxt = bus.ls_wdata[7:0];
                    end else begin
                        state_nxt = READ;
                    end
                end else if (bus.if_req) begin
                    base_nxt  = bus.if_addr;
                    len_nxt   = 3'd4;
                    owner_nxt = 1'b0;
                    asm_nxt   = 32'd0;
                    cnt_nxt   = 3'd1;
                    mem_a_nxt = addr_at(bus.if_addr, 3'd0);
                    state_nxt = READ;
                end
            end
            READ: begin
                cnt_nxt = cnt + 3'd1;
                if (cnt < len_n) mem_a_nxt = addr_at(base, cnt);
                if (cnt >= 3'd2) asm_nxt = merged;
                if (cnt == len_n + 3'd1) begin
                    state_nxt = DONE;
                    if (owner_ls) begin
                        ls_ok_nxt    = 1'b1;
                        ls_rdata_nxt = merged;
                    end else begin
                        if_ok_nxt   = 1'b1;
                        if_data_nxt = merged;
                    end
                end
            end
            WRITE: begin
                if (cnt < len_n) begin
                    mem_wr_nxt   = 1'b1;
                    mem_a_nxt    = addr_at(base, cnt);
                    mem_dout_nxt = get_byte(wdata, cnt[1:0]);
                    cnt_nxt      = cnt + 3'd1;
                end else begin
                    state_nxt = DONE;
                    ls_ok_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
                mem_a_nxt = '0;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= 3'd0;
            bus.if_ok    <= 1'b0;
            bus.if_data  <= 32'd0;
            bus.ls_ok    <= 1'b0;
            bus.ls_rdata <= 32'd0;
            bus.mem_a    <= '0;
            bus.mem_wr   <= 1'b0;
            bus.mem_dout <= 8'd0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            bus.if_ok    <= if_ok_nxt;
            bus.if_data  <= if_data_nxt;
            bus.ls_ok    <= ls_ok_nxt;
            bus.ls_rdata <= ls_rdata_nxt;
            bus.mem_a    <= mem_a_nxt;
            bus.mem_wr   <= mem_wr_nxt;
            bus.mem_dout <= mem_dout_nxt;
        end
    end

    // Transaction latches are only consulted after an IDLE acceptance, so they carry no reset.
    always_ff @(posedge clk) begin
        len_n    <= len_nxt;
        owner_ls <= owner_nxt;
        base     <= base_nxt;
        wdata    <= wdata_nxt;
        asm_buf  <= asm_nxt;
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte RAM model, directed requests, and a scoreboard monitor that
// pairs every if_ok/ls_ok pulse with the expected data and completion cycle.
module tb_mem_ctrl;
    localparam int AW = 17;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_checks;
    int   n_pass;
    exp_t if_q[$];
    exp_t ls_q[$];

    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [7:0]    pre_d;
    logic [7:0]    ram [0:(1<<AW)-1];

    mem_ctrl_if #(.ADDR_W(AW)) bus ();

    mem_ctrl #(.ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM: one-cycle read latency; preload port has priority over the controller's writes.
    always @(posedge clk) begin
        if (pre_we) ram[pre_a] <= pre_d;
        else if (bus.mem_wr) ram[bus.mem_a] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.if_ok || bus.ls_ok)
            check("ok_overlap", {31'd0, bus.if_ok & bus.ls_ok}, 32'd0);
        if (bus.if_ok) begin
            if (if_q.size() == 0) check("if_ok_unexpected", 32'd1, 32'd0);
            else begin
                e = if_q.pop_front();
                check("if_data", bus.if_data, e.data);
                check("if_ok_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
        if (bus.ls_ok) begin
            if (ls_q.size() == 0) check("ls_ok_unexpected", 32'd1, 32'd0);
            else begin
                e = ls_q.pop_front();
                if (e.chk) check("ls_rdata", bus.ls_rdata, e.data);
                check("ls_ok_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
        pre_we = 1'b1;
        pre_a  = a;
        pre_d  = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Waits (bounded) for the given ok, then lets the request go in the following cycle.
    task automatic wait_ok(input bit ls);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (ls ? bus.ls_ok : bus.if_ok) got = 1'b1;
        end
        if (!got) check(ls ? "ls_ok_timeout" : "if_ok_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (ls) bus.ls_req = 1'b0;
        else bus.if_req = 1'b0;
    endtask

    task automatic push(input bit ls, input logic [31:0] d, input int c, input bit chk);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        e.chk  = chk;
        if (ls) ls_q.push_back(e);
        else if_q.push_back(e);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] exp);
        @(posedge clk); #1;
        bus.if_req  = 1'b1;
        bus.if_addr = addr;
        push(1'b0, exp, cyc + 6, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("fetch_mem_a", 32'(bus.mem_a), 32'(AW'(addr + 32'(k))));
            check("fetch_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        end
        wait_ok(1'b0);
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [1:0] len,
                           input logic [31:0] exp, input int lat);
        @(posedge clk); #1;
        bus.ls_req  = 1'b1;
        bus.ls_we   = 1'b0;
        bus.ls_len  = len;
        bus.ls_addr = addr;
        push(1'b1, exp, cyc + lat, 1'b1);
        wait_ok(1'b1);
    endtask

    task automatic do_store(input logic [31:0] addr, input logic [31:0] wd);
        @(posedge clk); #1;
        bus.ls_req   = 1'b1;
        bus.ls_we    = 1'b1;
        bus.ls_len   = 2'b10;
        bus.ls_addr  = addr;
        bus.ls_wdata = wd;
        push(1'b1, 32'd0, cyc + 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("store_mem_wr", {31'd0, bus.mem_wr}, 32'd1);
            check("store_mem_a", 32'(bus.mem_a), 32'(AW'(addr + 32'(k))));
            check("store_mem_dout", {24'd0, bus.mem_dout}, {24'd0, wd[8*k +: 8]});
        end
        wait_ok(1'b1);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst = 1'b1;
        pre_we = 1'b0; pre_a = '0; pre_d = 8'd0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0;
        bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_len = 2'b00;
        bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0;
        @(posedge clk); #1;
        poke(17'h00100, 8'h13); poke(17'h00101, 8'h05);
        poke(17'h00102, 8'h10); poke(17'h00103, 8'h00);
        poke(17'h0002A, 8'hF0);
        poke(17'h00040, 8'h34); poke(17'h00041, 8'h12);
        poke(17'h00300, 8'hAA); poke(17'h00301, 8'hAA);
        poke(17'h00302, 8'hAA); poke(17'h00303, 8'hAA);
        poke(17'h1FFFE, 8'h11); poke(17'h1FFFF, 8'h22);
        poke(17'h00000, 8'h33); poke(17'h00001, 8'h44);

        @(negedge clk);
        check("rst_if_ok",    {31'd0, bus.if_ok},  32'd0);
        check("rst_if_data",  bus.if_data,         32'd0);
        check("rst_ls_ok",    {31'd0, bus.ls_ok},  32'd0);
        check("rst_ls_rdata", bus.ls_rdata,        32'd0);
        check("rst_mem_a",    32'(bus.mem_a),      32'd0);
        check("rst_mem_wr",   {31'd0, bus.mem_wr}, 32'd0);
        check("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        do_fetch(32'h0000_0100, 32'h0010_0513);
        do_load(32'h0000_002A, 2'b00, 32'h0000_00F0, 3);
        do_load(32'h0000_0040, 2'b01, 32'h0000_1234, 4);
        do_load(32'h0000_0100, 2'b11, 32'h0010_0513, 6);
        @(negedge clk);
        check("if_data_hold", bus.if_data, 32'h0010_0513);

        do_store(32'h0000_0200, 32'hDEAD_BEEF);
        do_fetch(32'h0000_0200, 32'hDEAD_BEEF);
        @(negedge clk);
        check("ls_rdata_hold", bus.ls_rdata, 32'h0010_0513);

        // Arbitration: both requests raised together, load/store served first.
        @(posedge clk); #1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_len = 2'b00; bus.ls_addr = 32'h0000_002A;
        bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
        push(1'b1, 32'h0000_00F0, cyc + 3, 1'b1);
        push(1'b0, 32'h0010_0513, cyc + 10, 1'b1);
        wait_ok(1'b1);
        wait_ok(1'b0);

        // Reset sampled at the edge that would launch byte 1 of a word store.
        @(posedge clk); #1;
        bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_len = 2'b10;
        bus.ls_addr = 32'h0000_0300; bus.ls_wdata = 32'h1122_3344;
        @(posedge clk);
        @(negedge clk);
        check("rw_mem_wr_c1", {31'd0, bus.mem_wr}, 32'd1);
        check("rw_mem_dout_c1", {24'd0, bus.mem_dout}, 32'h44);
        rst = 1'b1;
        bus.ls_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rw_mem_wr_c2", {31'd0, bus.mem_wr}, 32'd0);
        check("rw_mem_a_c2", 32'(bus.mem_a), 32'd0);
        check("rw_if_data_c2", bus.if_data, 32'd0);
        check("rw_ls_rdata_c2", bus.ls_rdata, 32'd0);
        @(negedge clk);
        check("rw_mem_wr_c3", {31'd0, bus.mem_wr}, 32'd0);
        repeat (8) @(posedge clk);
        #1;
        check("rw_ram_300", {24'd0, ram[17'h00300]}, 32'h44);
        check("rw_ram_301", {24'd0, ram[17'h00301]}, 32'hAA);
        check("rw_ram_302", {24'd0, ram[17'h00302]}, 32'hAA);
        check("rw_ram_303", {24'd0, ram[17'h00303]}, 32'hAA);

        do_fetch(32'h0001_FFFE, 32'h4433_2211);

        repeat (5) @(posedge clk);
        check("if_queue_empty", 32'(if_q.size()), 32'd0);
        check("ls_queue_empty", 32'(ls_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end
endmodule
